fetch_unit: RTL
===============

# fetch_unit

Instruction fetch stage sitting directly upstream of the `rom` instruction memory. It owns the program counter, drives the ROM word address, captures the ROM's one-cycle-latency read data, and presents instructions to decode through a valid/ready handshake. A 2-entry buffer absorbs decode back-pressure. A redirect port, driven by branch/jump resolution, flushes in-flight fetches.

## Interface
- `ADDR_WIDTH`, 10, ROM word-address width; must match the `rom` instance.
- `DATA_WIDTH`, 32, instruction width; must match the `rom` instance.
- `RESET_PC`, 32'h0000_0000, byte address fetched first after reset.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  reset; asynchronous assert, active-low.
- `rom_addr`  out  ADDR_WIDTH  ROM word address, `fetch_pc[ADDR_WIDTH+1:2]`.
- `rom_rdata`  in  DATA_WIDTH  ROM read data.
- `rom_rdata_valid`  in  1  ROM read-data qualifier.
- `redirect_valid`  in  1  load a new PC and flush.
- `redirect_pc`  in  32  byte address of the redirect target.
- `instr_valid`  out  1  `instr_data`/`instr_pc` hold a valid instruction.
- `instr_ready`  in  1  decode accepts the instruction this cycle.
- `instr_data`  out  DATA_WIDTH  instruction word.
- `instr_pc`  out  32  byte address of `instr_data`.
- `fetch_fault`  out  1  misaligned redirect trap; exists only with `FETCH_MISALIGN_TRAP_EN`.

## Operation
- **State:**
  - `fetch_pc` (32 b): next address to issue.
  - `pending` (1 b): one issued read is outstanding.
  - `pending_pc`: byte address of the outstanding read.
  - 2-entry FIFO of {pc, data}, with `count` ∈ {0,1,2}.
- **Pop:** occurs when `instr_valid && instr_ready`. `instr_valid` = `count != 0`. Outputs show the FIFO head.
- **Issue condition:** `count + pending - pop <= 1`, with the sum computed 3 bits wide.
  - On issue: `pending` ← 1, `pending_pc` ← `fetch_pc`, `fetch_pc` ← `fetch_pc + 4`.
  - Addition wraps modulo 2^32. `rom_addr` therefore wraps modulo 2^ADDR_WIDTH.
- **No issue:** `rom_addr` holds its value, and `pending` clears once its response is taken.
- **Response:** taken when `pending && rom_rdata_valid`. {`pending_pc`, `rom_rdata`} is pushed to the FIFO tail.
  - Push and pop in the same cycle are both legal.
  - The issue condition guarantees a push never overflows.
- **`rom_rdata_valid` low while `pending`:** `pending` stays set and the response is retried next cycle. `rom_addr` is not changed until the response is taken.
- **Redirect** (`redirect_valid` = 1) has priority over all other events that cycle:
  - `count` ← 0 and any response arriving this cycle is discarded.
  - A pop in the same cycle still counts as consumed by decode.
  - `rom_addr` is driven combinationally from `redirect_pc[ADDR_WIDTH+1:2]` and the target is issued this cycle.
  - Resulting state: `pending` ← 1, `pending_pc` ← `redirect_pc`, `fetch_pc` ← `redirect_pc + 4`.
  - Back-to-back redirects: the last one wins.
- **Decoding of `redirect_pc[1:0]`:** the low bits never reach `rom_addr`. Handling of non-zero low bits is set by the macro in Configuration.

## Timing
- **Reset values:**
  - `instr_valid`=0, `instr_data`=0, `instr_pc`=0, `rom_addr`=`RESET_PC[ADDR_WIDTH+1:2]`, `fetch_fault`=0.
  - `fetch_pc`=`RESET_PC`, `count`=0, `pending`=0.
- **Reset mid-operation:** discards the FIFO and the pending read immediately.
- **Sequence after reset release.** Cycle 0 is the first rising edge with `rst_n`=1:
  - Cycle 0: issue `RESET_PC`.
  - Cycle 1: ROM data is captured.
  - Cycle 2: `instr_valid`=1.
- **Latencies:**
  - Issue-to-`instr_valid`: 2 cycles.
  - Redirect-to-`instr_valid` for the target: 2 cycles.
- **Throughput:** 1 instruction/cycle while `instr_ready` is held high.
- **Back-pressure:** with `instr_ready` low, the FIFO fills to 2 and issue stops. `instr_data`/`instr_pc` are held stable while `instr_valid && !instr_ready`.

## Configuration
- **`FETCH_MISALIGN_TRAP_EN` defined:**
  - A redirect with `redirect_pc[1:0] != 0` flushes the FIFO, issues nothing and clears `pending`.
  - `fetch_fault` is set and stays 1, and fetch halts.
  - Only `rst_n` or a later aligned redirect clears `fetch_fault` and resumes fetch. The aligned redirect behaves as a normal redirect.
- **Not defined:** the `fetch_fault` port is absent and `redirect_pc[1:0]` is ignored (truncated). This applies to `rom_addr`, `fetch_pc` and `instr_pc`.

## Test plan
- **Reset fetch:** ROM word n = 32'hA000_0000+n, `RESET_PC`=0, `instr_ready`=1 → from cycle 2 after release, one instruction per cycle: (pc 0, A000_0000), (4, A000_0001), (8, A000_0002).
- **Back-pressure:** hold `instr_ready`=0 for 5 cycles after the first valid → `count` saturates at 2, head stays (pc 0, A000_0000). On release, pcs 0, 4, 8 follow with no gap and no duplicate.
- **Redirect with pop:** `redirect_valid`=1, `redirect_pc`=32'h40 while `instr_ready`=1 and FIFO full → in-flight data dropped. Two cycles later (pc 0x40, A000_0010) is delivered; no stale pc appears.
- **Wrap-around:** redirect to 32'hFFC with `ADDR_WIDTH`=10 → `rom_addr` goes 1023 then 0. `instr_pc` goes 0xFFC then 0x1000, with data A000_03FF then A000_0000.
- **Mid-run reset:** assert `rst_n`=0 with FIFO full → `instr_valid` drops to 0 asynchronously. After release, fetch restarts at `RESET_PC` with 2-cycle latency.
- **Misaligned redirect** (`FETCH_MISALIGN_TRAP_EN` defined): redirect to 32'h42 → `fetch_fault`=1 and `instr_valid` stays 0. A following redirect to 32'h80 clears the fault, and (0x80, A000_0020) arrives two cycles later.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, drives a 1-cycle-latency ROM and feeds decode through a 2-entry buffer.
// Optional FETCH_MISALIGN_TRAP_EN adds the fetch_fault port and halts fetch on a misaligned redirect.
module fetch_unit #(
    parameter int          ADDR_WIDTH = 10,
    parameter int          DATA_WIDTH = 32,
    parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    input  logic [DATA_WIDTH-1:0] rom_rdata,
    input  logic                  rom_rdata_valid,
    input  logic                  redirect_valid,
    input  logic [31:0]           redirect_pc,
    output logic                  instr_valid,
    input  logic                  instr_ready,
    output logic [DATA_WIDTH-1:0] instr_data,
    output logic [31:0]           instr_pc
`ifdef FETCH_MISALIGN_TRAP_EN
    ,
    output logic                  fetch_fault
`endif
);

    logic [31:0]           fetch_pc_reg, fetch_pc_next;
    logic                  pending_reg, pending_next;
    logic [31:0]           pending_pc_reg, pending_pc_next;
    logic [1:0]            count_reg, count_next;
    logic [ADDR_WIDTH-1:0] addr_reg;

    logic [31:0]           fifo_pc_reg   [2];
    logic [31:0]           fifo_pc_next  [2];
    logic [DATA_WIDTH-1:0] fifo_data_reg [2];
    logic [DATA_WIDTH-1:0] fifo_data_next[2];

    logic        pop, resp, push, issue;
    logic        redirect_go, redirect_bad, halted;
    logic [2:0]  occupancy;
    logic [1:0]  push_slot;
    logic [31:0] redirect_target;

`ifdef FETCH_MISALIGN_TRAP_EN
    logic fault_reg;

    assign redirect_bad = redirect_valid && (redirect_pc[1:0] != 2'b00);
    assign halted       = fault_reg;
    assign fetch_fault  = fault_reg;

    // The most recent redirect decides whether fetch is trapped or running.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fault_reg <= 1'b0;
        end else if (redirect_valid) begin
            fault_reg <= redirect_bad;
        end
    end
`else
    logic unused_pc_low;

    assign redirect_bad  = 1'b0;
    assign halted        = 1'b0;
    assign unused_pc_low = ^redirect_pc[1:0];
`endif

    assign redirect_target = {redirect_pc[31:2], 2'b00};
    assign redirect_go     = redirect_valid && !redirect_bad;

    assign instr_valid = (count_reg != 2'd0);
    assign instr_pc    = fifo_pc_reg[0];
    assign instr_data  = fifo_data_reg[0];

    assign pop  = instr_valid && instr_ready;
    assign resp = pending_reg && rom_rdata_valid;
    assign push = resp && !redirect_valid;

    // Slots already claimed after this cycle's pop; an outstanding read owns one.
    assign occupancy = {1'b0, count_reg} + {2'b00, pending_reg} - {2'b00, pop};
    // A new read may only go out once the previous one has been answered.
    assign issue     = !redirect_valid && !halted && (occupancy <= 3'd1) && (!pending_reg || resp);
    assign push_slot = count_reg - {1'b0, pop};

    always_comb begin
        rom_addr = addr_reg;
        if (redirect_go) begin
            rom_addr = redirect_pc[ADDR_WIDTH+1:2];
        end else if (issue) begin
            rom_addr = fetch_pc_reg[ADDR_WIDTH+1:2];
        end
    end

    always_comb begin
        fetch_pc_next   = fetch_pc_reg;
        pending_next    = pending_reg;
        pending_pc_next = pending_pc_reg;
        count_next      = count_reg + {1'b0, push} - {1'b0, pop};
        if (redirect_valid) begin
            count_next   = 2'd0;
            pending_next = redirect_go;
            if (redirect_go) begin
                pending_pc_next = redirect_target;
                fetch_pc_next   = redirect_target + 32'd4;
            end
        end else if (issue) begin
            pending_next    = 1'b1;
            pending_pc_next = fetch_pc_reg;
            fetch_pc_next   = fetch_pc_reg + 32'd4;
        end else if (resp) begin
            pending_next = 1'b0;
        end
    end

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            fifo_pc_next[i]   = fifo_pc_reg[i];
            fifo_data_next[i] = fifo_data_reg[i];
        end
        if (pop) begin
            fifo_pc_next[0]   = fifo_pc_reg[1];
            fifo_data_next[0] = fifo_data_reg[1];
        end
        if (push) begin
            fifo_pc_next[push_slot[0]]   = pending_pc_reg;
            fifo_data_next[push_slot[0]] = rom_rdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc_reg   <= RESET_PC;
            pending_reg    <= 1'b0;
            pending_pc_reg <= RESET_PC;
            count_reg      <= 2'd0;
            addr_reg       <= RESET_PC[ADDR_WIDTH+1:2];
        end else begin
            fetch_pc_reg   <= fetch_pc_next;
            pending_reg    <= pending_next;
            pending_pc_reg <= pending_pc_next;
            count_reg      <= count_next;
            addr_reg       <= rom_addr;
        end
    end

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_entry
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    fifo_pc_reg[gi]   <= 32'd0;
                    fifo_data_reg[gi] <= '0;
                end else begin
                    fifo_pc_reg[gi]   <= fifo_pc_next[gi];
                    fifo_data_reg[gi] <= fifo_data_next[gi];
                end
            end
        end
    endgenerate

endmodule
